dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's M-stage data port.
- Accepts store and load requests qualified by funct3 and drives a single-port synchronous SRAM macro (1-cycle read latency) with byte-lane write masks.
- Returns aligned, sign- or zero-extended load data one cycle later.
- Zero-initialises the SRAM after reset and flags misaligned accesses.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_load_align.sv | 29 ++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// MMIO register indices and the access-legality rule.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MMIO_SCRATCH  = 2'd0;
    localparam logic [1:0] MMIO_CYCLE_LO = 2'd1;
    localparam logic [1:0] MMIO_CYCLE_HI = 2'd2;
    localparam logic [1:0] MMIO_MISALIGN = 2'd3;

    // High for a misaligned half/word access or an unused funct3 code.
    function automatic logic access_error(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// dmem_load_align: picks the byte/half/word at the given offset of a 32-bit
// read word and sign- or zero-extends it according to funct3.
module dmem_load_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dout[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? dout[31:16] : dout[15:0];
        data     = '0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = dout;
            F3_BU:   data = {24'b0, byte_sel};
            F3_HU:   data = {16'b0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-sweeps the SRAM after reset, then serves M-stage
// loads/stores with 1-cycle load latency. Optional MMIO block: DMEM_MMIO_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_write_M,
    input  logic [31:0]           i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    input  logic [2:0]            i_funct3_MEM,
    output logic [DATA_WIDTH-1:0] o_read_data_W,
    output logic                  o_misaligned,
    output logic                  o_init_done,
    output logic                  o_sram_csb,
    output logic                  o_sram_web,
    output logic [3:0]            o_sram_wmask,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    // Request contract: in RUN a request is presented every cycle and always
    // accepted (no back-pressure); its load data/error appear exactly one cycle later.
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [1:0]            off;
    logic                  req_err;
    logic                  is_mmio;
    logic [3:0]            st_mask;
    logic [31:0]           st_din;
    logic                  ld_valid_q, err_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [31:0]           dout_src;
    logic [31:0]           aligned;
    logic                  unused_addr_bits;

    assign off              = i_data_addr_M[1:0];
    assign req_err          = access_error(i_funct3_MEM, off);
    assign unused_addr_bits = ^i_data_addr_M[31:ADDR_WIDTH+2];

    always_comb begin
        case (i_funct3_MEM[1:0])
            2'b00: begin
                st_mask = 4'b0001 << off;
                st_din  = {4{i_write_data_M[7:0]}};
            end
            2'b01: begin
                st_mask = off[1] ? 4'b1100 : 4'b0011;
                st_din  = {2{i_write_data_M[15:0]}};
            end
            default: begin
                st_mask = 4'hF;
                st_din  = i_write_data_M;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        o_sram_csb   = 1'b1;
        o_sram_web   = 1'b1;
        o_sram_wmask = 4'h0;
        o_sram_addr  = i_data_addr_M[ADDR_WIDTH+1:2];
        o_sram_din   = '0;
        case (state_q)
            ST_INIT: begin
                o_sram_csb   = 1'b0;
                o_sram_web   = 1'b0;
                o_sram_wmask = 4'hF;
                o_sram_addr  = cnt_q;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!req_err && !is_mmio) begin
                    o_sram_csb = 1'b0;
                    if (i_mem_write_M) begin
                        o_sram_web   = 1'b0;
                        o_sram_wmask = st_mask;
                        o_sram_din   = st_din;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            o_init_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_init_done <= (state_d == ST_RUN);
            if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
        end else if (state_q == ST_RUN) begin
            ld_valid_q <= !i_mem_write_M;
            err_q      <= req_err;
            f3_q       <= i_funct3_MEM;
            off_q      <= off;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] scratch_q, mmio_rdata_q, mis_cnt_q;
    logic [63:0] cycle_q;
    logic        mmio_q;
    logic [1:0]  mmio_idx;

    assign is_mmio  = i_data_addr_M[31];
    assign mmio_idx = i_data_addr_M[3:2];

    // Read values are sampled at the request edge so MMIO loads share the SRAM latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scratch_q    <= '0;
            mmio_rdata_q <= '0;
            mis_cnt_q    <= '0;
            cycle_q      <= '0;
            mmio_q       <= 1'b0;
        end else if (state_q == ST_RUN) begin
            cycle_q <= cycle_q + 64'd1;
            if (err_q) mis_cnt_q <= mis_cnt_q + 32'd1;
            mmio_q <= is_mmio;
            if (is_mmio && !req_err && i_mem_write_M && mmio_idx == MMIO_SCRATCH) begin
                for (int k = 0; k < 4; k++)
                    if (st_mask[k]) scratch_q[8*k +: 8] <= st_din[8*k +: 8];
            end
            case (mmio_idx)
                MMIO_SCRATCH:  mmio_rdata_q <= scratch_q;
                MMIO_CYCLE_LO: mmio_rdata_q <= cycle_q[31:0];
                MMIO_CYCLE_HI: mmio_rdata_q <= cycle_q[63:32];
                default:       mmio_rdata_q <= mis_cnt_q;
            endcase
        end
    end

    assign dout_src = mmio_q ? mmio_rdata_q : i_sram_dout;
`else
    assign is_mmio  = 1'b0;
    assign dout_src = i_sram_dout;
`endif

    dmem_load_align u_align (
        .dout   (dout_src),
        .funct3 (f3_q),
        .offset (off_q),
        .data   (aligned)
    );

    assign o_read_data_W = (ld_valid_q && !err_q) ? aligned : '0;
    assign o_misaligned  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_WIDTH=4) with an SRAM model,
// directed vector table, randomized traffic against a byte-array reference.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NV    = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_mem_write_M;
    logic [31:0] i_data_addr_M, i_write_data_M;
    logic [2:0]  i_funct3_MEM;
    logic [31:0] o_read_data_W;
    logic        o_misaligned, o_init_done, o_sram_csb, o_sram_web;
    logic [3:0]  o_sram_wmask;
    logic [AW-1:0] o_sram_addr;
    logic [31:0] o_sram_din;
    logic [31:0] i_sram_dout;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_write_M  (i_mem_write_M),
        .i_data_addr_M  (i_data_addr_M),
        .i_write_data_M (i_write_data_M),
        .i_funct3_MEM   (i_funct3_MEM),
        .o_read_data_W  (o_read_data_W),
        .o_misaligned   (o_misaligned),
        .o_init_done    (o_init_done),
        .o_sram_csb     (o_sram_csb),
        .o_sram_web     (o_sram_web),
        .o_sram_wmask   (o_sram_wmask),
        .o_sram_addr    (o_sram_addr),
        .o_sram_din     (o_sram_din),
        .i_sram_dout    (i_sram_dout)
    );

    // SRAM macro model: synchronous, 1-cycle read latency; fill_req loads garbage.
    logic [31:0] sram [DEPTH];
    logic        fill_req = 1'b0;
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= $urandom;
        end else if (!o_sram_csb) begin
            if (!o_sram_web) begin
                for (int k = 0; k < 4; k++)
                    if (o_sram_wmask[k]) sram[o_sram_addr][8*k +: 8] <= o_sram_din[8*k +: 8];
            end else begin
                i_sram_dout <= sram[o_sram_addr];
            end
        end
    end

    // Reference: byte-addressed memory, 4*DEPTH bytes, upper address bits alias.
    logic [7:0]  ref_mem [4*DEPTH];
    logic [32:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_csb;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_din;
    } vec_t;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] f3, output logic [31:0] rd, output logic mis,
                                       output logic xcsb, output logic [3:0] xmask, output logic [31:0] xdin);
        int size, b, lane;
        logic [31:0] v;
        mis  = (f3 == 3'd3) || (f3 >= 3'd6) || ((f3 == 3'd1 || f3 == 3'd5) && a[0])
               || (f3 == 3'd2 && a[1:0] != 2'd0);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        rd = '0; xcsb = 1'b1; xmask = '0; xdin = '0;
        if (!mis) begin
            xcsb = 1'b0;
            b = int'(a[AW+1:0]);
            if (we) begin
                for (int j = 0; j < size; j++) begin
                    ref_mem[b+j] = wd[8*j +: 8];
                    lane = (b + j) % 4;
                    xmask[lane] = 1'b1;
                    xdin[8*lane +: 8] = wd[8*j +: 8];
                end
            end else begin
                v = '0;
                for (int j = 0; j < size; j++) v[8*j +: 8] = ref_mem[b+j];
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] xrd, input logic xmis, input logic xcsb, input logic [3:0] xmask,
                        input logic [31:0] xdin, input bit full_din);
        logic [32:0] e;
        logic [31:0] dm;
        i_mem_write_M  = we;
        i_data_addr_M  = a;
        i_write_data_M = wd;
        i_funct3_MEM   = f3;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("read_data", o_read_data_W, e[31:0]);
            chk("misaligned", 32'(o_misaligned), 32'(e[32]));
        end
        chk("csb", 32'(o_sram_csb), 32'(xcsb));
        if (!xcsb) begin
            chk("web", 32'(o_sram_web), 32'(!we));
            chk("wmask", 32'(o_sram_wmask), 32'(xmask));
            chk("addr", 32'(o_sram_addr), 32'(a[AW+1:2]));
            if (we) begin
                for (int k = 0; k < 4; k++) dm[8*k +: 8] = {8{full_din | xmask[k]}};
                chk("din", o_sram_din & dm, xdin & dm);
            end
        end
        exp_q.push_back({xmis, xrd});
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] rd, xdin;
        logic mis, xcsb;
        logic [3:0] xmask;
        ref_access(we, a, wd, f3, rd, mis, xcsb, xmask, xdin);
        step(we, a, wd, f3, rd, mis, xcsb, xmask, xdin, 1'b0);
    endtask

    task automatic drain();
        logic [32:0] e;
        i_mem_write_M = 1'b0; i_data_addr_M = '0; i_funct3_MEM = F3_W;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("drain_read_data", o_read_data_W, e[31:0]);
            chk("drain_misaligned", 32'(o_misaligned), 32'(e[32]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        i_mem_write_M  = 1'($urandom);
        i_data_addr_M  = $urandom;
        i_write_data_M = $urandom;
        i_funct3_MEM   = 3'($urandom_range(0, 7));
    endtask

    // Reset, then follow the zero sweep; abort_at >= 0 re-asserts reset at that count.
    task automatic run_init(input int abort_at);
        rst = 1'b0;
        rand_inputs();
        fill_req = 1'b1;
        @(posedge clk);
        #1 fill_req = 1'b0;
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
        @(negedge clk);
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_misaligned", 32'(o_misaligned), 32'd0);
        chk("rst_read_data", o_read_data_W, 32'd0);
        chk("rst_csb", 32'(o_sram_csb), 32'd0);
        chk("rst_web", 32'(o_sram_web), 32'd0);
        chk("rst_wmask", 32'(o_sram_wmask), 32'hF);
        chk("rst_din", o_sram_din, 32'd0);
        chk("rst_addr", 32'(o_sram_addr), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_init_done", 32'(o_init_done), 32'd0);
                chk("abort_addr", 32'(o_sram_addr), 32'd0);
                chk("abort_wmask", 32'(o_sram_wmask), 32'hF);
                return;
            end
            chk("sweep_init_done", 32'(o_init_done), 32'd0);
            chk("sweep_addr", 32'(o_sram_addr), 32'(c));
            chk("sweep_csb", 32'(o_sram_csb), 32'd0);
            chk("sweep_web", 32'(o_sram_web), 32'd0);
            chk("sweep_wmask", 32'(o_sram_wmask), 32'hF);
            chk("sweep_din", o_sram_din, 32'd0);
            rand_inputs();
            @(posedge clk);
            @(negedge clk);
        end
        chk("init_done_rise", 32'(o_init_done), 32'd1);
        chk("post_init_misaligned", 32'(o_misaligned), 32'd0);
        i_mem_write_M = 1'b0; i_data_addr_M = '0; i_funct3_MEM = F3_W;
        @(posedge clk);
        #1;
        for (int w = 0; w < DEPTH; w++) chk("swept_word", sram[w], 32'd0);
    endtask

    initial begin
        logic [31:0] rd, xdin, a, wd, v1, v2;
        logic mis, xcsb, we;
        logic [3:0] xmask;
        logic [2:0] f3;
        int sz, r;

        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, F3_W,  32'h0,         1'b0, 1'b0, 4'hF,    32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFFDE,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[2]  = '{1'b0, 32'h13, 32'h0,        F3_BU, 32'h000000DE,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[3]  = '{1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFFDEAD,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,        F3_HU, 32'h0000BEEF,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[5]  = '{1'b0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[6]  = '{1'b1, 32'h21, 32'h7F,       F3_B,  32'h0,         1'b0, 1'b0, 4'b0010, 32'h7F7F7F7F};
        vecs[7]  = '{1'b0, 32'h20, 32'h0,        F3_W,  32'h00007F00,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[8]  = '{1'b1, 32'h03, 32'h1234,     F3_H,  32'h0,         1'b1, 1'b1, 4'h0,    32'h0};
        vecs[9]  = '{1'b0, 32'h06, 32'h0,        F3_W,  32'h0,         1'b1, 1'b1, 4'h0,    32'h0};
        vecs[10] = '{1'b0, 32'h00, 32'h0,        F3_W,  32'h0,         1'b0, 1'b0, 4'h0,    32'h0};
        vecs[11] = '{1'b0, 32'h10, 32'h0,        3'd3,  32'h0,         1'b1, 1'b1, 4'h0,    32'h0};
        vecs[12] = '{1'b0, 32'h11, 32'h0,        F3_HU, 32'h0,         1'b1, 1'b1, 4'h0,    32'h0};
        vecs[13] = '{1'b0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[14] = '{1'b1, 32'h12, 32'hCAFE,     F3_H,  32'h0,         1'b0, 1'b0, 4'b1100, 32'hCAFECAFE};
        vecs[15] = '{1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFFCAFE,  1'b0, 1'b0, 4'h0,    32'h0};
        vecs[16] = '{1'b0, 32'h10, 32'h0,        F3_B,  32'hFFFFFFEF,  1'b0, 1'b0, 4'h0,    32'h0};

        rand_inputs();
        run_init(-1);

        for (int w = 0; w < DEPTH; w++) model_step(1'b0, 32'(w * 4), 32'h0, F3_W);

        for (int i = 0; i < NV; i++) begin
            ref_access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].f3, rd, mis, xcsb, xmask, xdin);
            step(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].f3, vecs[i].exp_rd, vecs[i].exp_mis,
                 vecs[i].exp_csb, vecs[i].exp_wmask, vecs[i].exp_din, 1'b1);
        end

        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 2) == 0);
            if (we) begin
                r  = $urandom_range(0, 9);
                f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd6;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
`ifdef DMEM_MMIO_EN
            a[31] = 1'b0;
`endif
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            wd = $urandom;
            model_step(we, a, wd, f3);
        end
        drain();
        for (int w = 0; w < DEPTH; w++)
            chk("mem_contents", sram[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        run_init(7);
        run_init(-1);
        model_step(1'b0, 32'h1C, 32'h0, F3_W);
        drain();

`ifdef DMEM_MMIO_EN
        step(1'b1, 32'h8000_0000, 32'hA5A5A5A5, F3_W, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b0, 32'h8000_0000, 32'h0,        F3_W, 32'hA5A5A5A5, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b1, 32'h8000_0001, 32'h3C,       F3_B, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b1, 32'h8000_0004, 32'hFFFFFFFF, F3_W, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b0, 32'h8000_0000, 32'h0,        F3_W, 32'hA5A53CA5, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0000_0002, 32'h0,        F3_W, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0001, 32'h0,        F3_H, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        step(1'b0, 32'h8000_0003, 32'h0,        F3_H, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        model_step(1'b0, 32'h0, 32'h0, F3_W);
        step(1'b0, 32'h8000_000C, 32'h0,        F3_W, 32'd3, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
        drain();

        i_mem_write_M = 1'b0; i_data_addr_M = 32'h8000_0004; i_funct3_MEM = F3_W;
        @(posedge clk);
        #1 i_data_addr_M = '0;
        @(negedge clk);
        v1 = o_read_data_W;
        repeat (6) @(posedge clk);
        #1 i_data_addr_M = 32'h8000_0004;
        @(posedge clk);
        #1 i_data_addr_M = '0;
        @(negedge clk);
        v2 = o_read_data_W;
        chk("cycle_delta", v2 - v1, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
